// File: rtl/bsg_counter_overflow_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_overflow_rr_sched
// Purpose  : Round-robin scheduler sharing one overflow-counter timer between
//            num_req_p requesters. Optional done-interval statistics counter
//            enabled by macro BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_overflow_rr_sched #(
    parameter int                 num_req_p = 4,
    parameter int                 width_p   = 24,
    parameter logic [width_p-1:0] max_val_p = width_p'(24'hFFFFFF)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [num_req_p-1:0] req_i,
    input  logic                 tick_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [num_req_p-1:0] done_o,
    output logic [width_p-1:0]   count_o,
`ifdef BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN
    output logic [15:0]          done_cnt_o,
`endif
    output logic                 busy_o
);

    localparam int IDX_W = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [num_req_p-1:0]   grant_q, grant_d;
    logic [num_req_p-1:0]   done_q, done_d;
    logic [width_p-1:0]     count_q, count_d;

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       ptr_after_grant;

    // Scan downward so the candidate closest to the pointer is the final winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % num_req_p]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr_q) + k) % num_req_p);
            end
        end
    end

    assign ptr_after_grant = IDX_W'((int'(gidx_q) + 1) % num_req_p);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        done_d  = '0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                count_d = '0;
                if (sel_found) begin
                    state_d          = RUN;
                    gidx_d           = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over a coincident overflow.
                if (!req_i[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = ptr_after_grant;
                end else if (tick_i && (count_q == max_val_p)) begin
                    state_d = DONE;
                    count_d = '0;
                    done_d  = grant_q;
                    ptr_d   = ptr_after_grant;
                end else if (tick_i) begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign busy_o  = (state_q != IDLE);

`ifdef BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN
    logic [15:0] done_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_cnt_q <= '0;
        end else if ((state_d == DONE) && (state_q == RUN) && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign done_cnt_o = done_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_overflow_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_counter_overflow_rr_sched
// Purpose  : Directed and random stimulus against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_counter_overflow_rr_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MAX = 5;

    logic         clk;
    logic         reset_i;
    logic [N-1:0] req_i;
    logic         tick_i;
    logic [N-1:0] grant_o;
    logic [N-1:0] done_o;
    logic [W-1:0] count_o;
    logic         busy_o;
`ifdef BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN
    logic [15:0]  done_cnt_o;
`endif

    bsg_counter_overflow_rr_sched #(
        .num_req_p (N),
        .width_p   (W),
        .max_val_p (W'(MAX))
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .tick_i     (tick_i),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .count_o    (count_o),
`ifdef BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN
        .done_cnt_o (done_cnt_o),
`endif
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 when idle), phase, counter, pointer.
    int  m_owner = -1;
    bit  m_done_phase = 0;
    int  m_cnt = 0;
    int  m_ptr = 0;
    int  m_dcnt = 0;
    logic [N-1:0] m_req;

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        return onehot(m_owner);
    endfunction

    function automatic logic [N-1:0] exp_done();
        return m_done_phase ? onehot(m_owner) : '0;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input bit tick, input bit rst);
        if (rst) begin
            m_owner = -1; m_done_phase = 0; m_cnt = 0; m_ptr = 0; m_dcnt = 0;
        end else if (m_done_phase) begin
            m_owner = -1; m_done_phase = 0;
        end else if (m_owner < 0) begin
            m_cnt = 0;
            for (int k = N - 1; k >= 0; k--)
                if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
        end else if (tick && m_cnt == MAX) begin
            m_ptr = (m_owner + 1) % N; m_cnt = 0; m_done_phase = 1;
            if (m_dcnt < 65535) m_dcnt++;
        end else if (tick) begin
            m_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("grant", 32'(grant_o), 32'(exp_grant()));
        chk("done",  32'(done_o),  32'(exp_done()));
        chk("count", 32'(count_o), 32'(m_cnt));
        chk("busy",  32'(busy_o),  32'(m_owner >= 0));
`ifdef BSG_COUNTER_OVERFLOW_RR_SCHED_STATS_EN
        chk("done_cnt", 32'(done_cnt_o), 32'(m_dcnt));
`endif
    endtask

    // Drive, advance one edge, then compare just after it.
    task automatic cycle(input logic [N-1:0] req, input bit tick, input bit rst);
        req_i = req; tick_i = tick; reset_i = rst;
        model_step(req, tick, rst);
        @(posedge clk);
        #1;
        check_all();
    endtask

    int order[$];
    int prev_owner;

    initial begin
        req_i = '0; tick_i = 1'b0; reset_i = 1'b1;
        @(posedge clk); #1;
        cycle('0, 1'b0, 1'b1);

        // Basic interval on requester 1; it drops its request after done.
        m_req = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            cycle(m_req, 1'b1, 1'b0);
            m_req &= ~done_o;
        end
        chk("basic_idle", 32'(busy_o), 32'd0);

        // Round robin with all four requesting, each dropping after its done.
        cycle('0, 1'b0, 1'b1);
        m_req = 4'b1111;
        prev_owner = -1;
        for (int c = 0; c < 60 && m_req != '0; c++) begin
            cycle(m_req, 1'b1, 1'b0);
            if (m_owner >= 0 && m_owner != prev_owner && !m_done_phase)
                for (int i = 0; i < N; i++) if (grant_o[i]) order.push_back(i);
            prev_owner = m_owner;
            m_req &= ~done_o;
        end
        chk("rr_len", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i));
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0);
        chk("rr_wrap", 32'(grant_o), 32'b0001);

        // Tick gating on requester 0.
        cycle('0, 1'b0, 1'b1);
        m_req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            cycle(m_req, c[0] == 1'b0, 1'b0);
            m_req &= ~done_o;
        end

        // Abort of requester 2 at count 3 while requester 3 waits.
        cycle('0, 1'b0, 1'b1);
        for (int c = 0; c < 10 && !(m_owner == 2 && m_cnt == 3); c++)
            cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        chk("abort_done", 32'(done_o), 32'd0);
        cycle(4'b1000, 1'b1, 1'b0);
        chk("abort_regrant", 32'(grant_o), 32'b1000);

        // Abort coincident with overflow.
        cycle('0, 1'b0, 1'b1);
        for (int c = 0; c < 10 && !(m_owner == 0 && m_cnt == MAX); c++)
            cycle(4'b0001, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        chk("abort_ovf_done", 32'(done_o), 32'd0);
        chk("abort_ovf_busy", 32'(busy_o), 32'd0);

        // Reset at count 2, then three completions.
        cycle('0, 1'b0, 1'b1);
        for (int c = 0; c < 10 && m_cnt != 2; c++) cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b1);
        m_req = 4'b0001;
        for (int c = 0; c < 40 && m_dcnt < 3; c++) begin
            cycle(m_req, 1'b1, 1'b0);
            m_req = (done_o != '0) ? 4'b0000 : 4'b0001;
        end
        chk("three_done", 32'(m_dcnt), 32'd3);

        // Random traffic: requesters raise, drop after done, occasionally abort.
        m_req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (done_o[i]) m_req[i] = 1'b0;
                else if (!m_req[i]) m_req[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(60) == 0) m_req[i] = 1'b0;
            end
            cycle(m_req, $urandom_range(3) != 0, $urandom_range(400) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
